// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types, lane constants and the alignment helper for the
//                MEM-stage data RAM access unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Lane widths of the 32-bit data word
    localparam int c_byte_width = 8;
    localparam int c_half_width = 16;
    localparam int c_word_width = 32;

    // Access size as encoded on req_size
    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_t;

    // Access-unit sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } mau_state_t;

    // True when the size is illegal or the byte offset breaks natural alignment
    function automatic logic mem_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: mem_misaligned = 1'b0;
            MEM_HALF: mem_misaligned = offset[0];
            MEM_WORD: mem_misaligned = (offset != 2'b00);
            default:  mem_misaligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational little-endian lane logic: merges store data
//                into an existing word, extracts and extends load data, and
//                flags misaligned or illegal accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_is_unsigned,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_merged,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [c_byte_width-1:0] w_byte;
    logic [c_half_width-1:0] w_half;

    assign w_byte     = i_old_word[{i_offset, 3'b000} +: c_byte_width];
    assign w_half     = i_offset[1] ? i_old_word[31:16] : i_old_word[15:0];
    assign o_misalign = mem_misaligned(i_size, i_offset);

    // Store merge: replace only the addressed lane(s) of the old word
    always_comb begin
        o_merged = i_old_word;
        case (i_size)
            MEM_BYTE: o_merged[{i_offset, 3'b000} +: c_byte_width] = i_store_data[c_byte_width-1:0];
            MEM_HALF: begin
                if (i_offset[1]) begin
                    o_merged[31:16] = i_store_data[c_half_width-1:0];
                end else begin
                    o_merged[15:0] = i_store_data[c_half_width-1:0];
                end
            end
            MEM_WORD: o_merged = i_store_data;
            default:  o_merged = i_old_word;
        endcase
    end

    // Load extraction: pick the lane and sign- or zero-extend it
    always_comb begin
        o_load_data = '0;
        case (i_size)
            MEM_BYTE: o_load_data = i_is_unsigned ? {24'b0, w_byte}
                                                  : {{24{w_byte[c_byte_width-1]}}, w_byte};
            MEM_HALF: o_load_data = i_is_unsigned ? {16'b0, w_half}
                                                  : {{16{w_half[c_half_width-1]}}, w_half};
            MEM_WORD: o_load_data = i_old_word;
            default:  o_load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage initiator for the data RAM. Turns byte/half/word
//                loads and stores into word-aligned RAM cycles, using a
//                read-modify-write for sub-word stores, and reports
//                misaligned or illegal-size accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_mem_write,
    output logic                  ram_mem_read,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    mau_state_t            r_state;
    logic                  r_write;
    mem_size_t             r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_word;

    logic                  w_accept;
    mem_size_t             w_req_size;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_misalign;

    assign req_ready  = (r_state == IDLE) && rst_n;
    assign w_accept   = req_valid && req_ready;
    assign w_req_size = mem_size_t'(req_size);

    // Lane logic works only on latched fields, so no req_* path reaches ram_*
    mem_lane_align u_lane_align (
        .i_size        (r_size),
        .i_offset      (r_addr[1:0]),
        .i_is_unsigned (r_unsigned),
        .i_old_word    (r_word),
        .i_store_data  (r_wdata),
        .o_merged      (w_merged),
        .o_load_data   (w_load_data),
        .o_misalign    (w_misalign)
    );

    // Sequencer: latch the request, then walk RD/WR as the access type needs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_size     <= MEM_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (mem_misaligned(w_req_size, req_addr[1:0])) begin
                            r_state <= RESP;
                        end else if (req_write && (w_req_size == MEM_WORD)) begin
                            r_state <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    r_word  <= ram_read_data;
                    r_state <= r_write ? WR : RESP;
                end
                WR:      r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM strobes and bus decoded purely from registered state
    always_comb begin
        ram_mem_read   = (r_state == RD);
        ram_mem_write  = (r_state == WR);
        ram_addr       = '0;
        ram_write_data = '0;
        if ((r_state == RD) || (r_state == WR)) begin
            ram_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        end
        if (r_state == WR) begin
            ram_write_data = w_merged;
        end
    end

    // Response: one-cycle pulse; data and error forced to 0 outside RESP.
    // The error flag is re-derived from the latched size/offset, which is
    // exactly what decided the error path at accept time.
    always_comb begin
        rsp_valid = (r_state == RESP);
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (r_state == RESP) begin
            rsp_err = w_misalign;
            if (!r_write && !w_misalign) begin
                rsp_rdata = w_load_data;
            end
        end
    end

endmodule
`default_nettype wire
